wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the 128-bit memory bus.
- Lets a second master (loader/DMA/debug port) share the single wb_ram with the memcontrol cache.
- Grants are registered and held for the whole cycle (cyc-locked), with round-robin priority between the masters.
- A watchdog terminates any strobe the slave never answers.

---
 rtl/wb_arbiter2.sv | 182 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: cyc-locked registered grant, round-robin
// priority on contention, and a watchdog that errors out strobes the slave never answers.
module wb_arbiter2 #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 64,
   localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   input  logic                  m0_we_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_cyc_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic                  m0_rty_o,

   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   input  logic                  m1_we_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_cyc_i,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  m1_rty_o,

   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   output logic                  s_we_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   output logic                  s_stb_o,
   output logic                  s_cyc_o,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,

   output logic [1:0]            grant_o
);

   // Encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_t;

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   logic slave_resp;
   logic wd_hit;
   logic wd_fire;
   logic s_stb;

   assign slave_resp = s_ack_i | s_err_i | s_rty_i;

   // wd_hit masks the slave strobe and depends only on registered state, so no
   // path runs from the slave responses back to the slave; wd_fire additionally
   // yields to a response arriving in the same cycle.
   assign wd_hit  = (TIMEOUT > 0) && (state_q != ST_IDLE) &&
                    (wd_cnt_q == WD_W'(TIMEOUT));
   assign wd_fire = wd_hit & ~slave_resp;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_d = last_grant_q ? ST_OWN0 : ST_OWN1;
            else if (m0_cyc_i)
               state_d = ST_OWN0;
            else if (m1_cyc_i)
               state_d = ST_OWN1;
         end
         ST_OWN0: begin
            if (!m0_cyc_i)
               state_d = m1_cyc_i ? ST_OWN1 : ST_IDLE;
         end
         ST_OWN1: begin
            if (!m1_cyc_i)
               state_d = m0_cyc_i ? ST_OWN0 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_d == ST_OWN0 && state_q != ST_OWN0)
         last_grant_d = 1'b0;
      else if (state_d == ST_OWN1 && state_q != ST_OWN1)
         last_grant_d = 1'b1;
   end

   always_comb begin
      wd_cnt_d = '0;
      if (TIMEOUT > 0 && state_d == state_q && !slave_resp && s_stb)
         wd_cnt_d = wd_cnt_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   assign grant_o = state_q;
   assign s_stb_o = s_stb;

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_stb   = 1'b0;
      s_cyc_o = 1'b0;
      unique case (state_q)
         ST_OWN0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb   = m0_stb_i & ~wd_hit;
            s_cyc_o = m0_cyc_i & ~wd_hit;
         end
         ST_OWN1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb   = m1_stb_i & ~wd_hit;
            s_cyc_o = m1_cyc_i & ~wd_hit;
         end
         default: ;
      endcase
   end

   // An owner that has already dropped cyc has aborted; nothing is returned to it.
   always_comb begin
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      unique case (state_q)
         ST_OWN0: begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i & m0_cyc_i;
            m0_err_o = (s_err_i | wd_fire) & m0_cyc_i;
            m0_rty_o = s_rty_i & m0_cyc_i;
         end
         ST_OWN1: begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i & m1_cyc_i;
            m1_err_o = (s_err_i | wd_fire) & m1_cyc_i;
            m1_rty_o = s_rty_i & m1_cyc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a small memory slave, master driver tasks and a
// response scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_wb_arbiter2;
   localparam int DW = 128;
   localparam int AW = 16;
   localparam int SW = DW / 8;
   localparam int EW = DW + 4;
   localparam logic [1:0] K_ACK = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;
   localparam logic [1:0] K_RTY = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [AW-1:0] m_adr [2];
   logic [DW-1:0] m_dat [2];
   logic          m_we  [2];
   logic [SW-1:0] m_sel [2];
   logic          m_stb [2];
   logic          m_cyc [2];

   logic [DW-1:0] m0_dat_o, m1_dat_o;
   logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [DW-1:0] s_dat_i = '0;
   logic          s_we_o, s_stb_o, s_cyc_o;
   logic [SW-1:0] s_sel_o;
   logic          s_ack_i = 1'b0;
   logic          s_err_i, s_rty_i;
   logic [1:0]    grant_o;

   wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o), .m0_we_i(m_we[0]),
      .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o), .m1_we_i(m_we[1]),
      .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant_o(grant_o)
   );

   logic [1:0] r_ack, r_err, r_rty, r_any;
   assign r_ack = {m1_ack_o, m0_ack_o};
   assign r_err = {m1_err_o, m0_err_o};
   assign r_rty = {m1_rty_o, m0_rty_o};
   assign r_any = r_ack | r_err | r_rty;

   int tests_run = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {check_data, master, kind, data}
   task automatic push(input int m, input logic [1:0] kind, input logic chk, input logic [DW-1:0] d);
      logic mb;
      mb = (m == 1);
      exp_q.push_back({chk, mb, kind, d});
   endtask

   // Slave memory: word i initialised to {1111_00ii, 2222_00ii, 3333_00ii, 4444_00ii}.
   logic [DW-1:0] mem [0:255];
   logic          slave_en;

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = {32'h11110000 | i, 32'h22220000 | i, 32'h33330000 | i, 32'h44440000 | i};
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [SW-1:0] sel);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < SW; b++)
         if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (slave_en && s_cyc_o && s_stb_o && !s_ack_i) begin
         if (s_we_o)
            mem[s_adr_o[7:0]] <= merge(mem[s_adr_o[7:0]], s_dat_o, s_sel_o);
         s_dat_i <= mem[s_adr_o[7:0]];
         s_ack_i <= 1'b1;
      end else begin
         s_ack_i <= 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      logic [1:0]    k;
      logic [EW-1:0] e;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            if (r_any[m]) begin
               k = r_ack[m] ? K_ACK : (r_err[m] ? K_ERR : K_RTY);
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected response m%0d", m), DW'(k), '0);
               end else begin
                  e = exp_q.pop_front();
                  check("resp master", DW'(m), DW'(e[DW+2]));
                  check("resp kind", DW'(k), DW'(e[DW+1:DW]));
                  if (e[DW+3])
                     check("resp data", (m == 1) ? m1_dat_o : m0_dat_o, e[DW-1:0]);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_start(input int m, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] d, input logic [SW-1:0] sel);
      m_adr[m] = a;
      m_we[m]  = we;
      m_dat[m] = d;
      m_sel[m] = sel;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
   endtask

   task automatic m_idle(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
   endtask

   task automatic wait_resp(input int m, input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (r_any[m]) return;
      end
      check({name, " response timeout"}, '0, 1);
   endtask

   task automatic wait_grant(input logic [1:0] g, input string name);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (grant_o == g) return;
      end
      check({name, " grant timeout"}, DW'(grant_o), DW'(g));
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic ok;
      rst = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
      slave_en = 1'b1;
      for (int m = 0; m < 2; m++) begin
         m_adr[m] = '0;
         m_dat[m] = '0;
         m_sel[m] = '0;
         m_idle(m);
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("reset grant", DW'(grant_o), '0);
      check("reset s_cyc/s_stb", DW'({s_cyc_o, s_stb_o}), '0);
      check("reset m0 outputs", DW'({m0_ack_o, m0_err_o, m0_rty_o}), '0);
      rst = 1'b1;

      // Single m0 read, m1 idle
      push(0, K_ACK, 1'b1, 128'h11110010_22220010_33330010_44440010);
      step();
      m_start(0, 16'h0010, 1'b0, '0, '1);
      @(negedge clk);
      check("t1 grant latency", DW'(grant_o), DW'(2'b00));
      @(negedge clk);
      check("t1 grant m0", DW'(grant_o), DW'(2'b01));
      check("t1 s_adr", DW'(s_adr_o), DW'(16'h0010));
      check("t1 s_cyc", DW'(s_cyc_o), 1);
      wait_resp(0, "t1");
      check("t1 m1 dat zero", m1_dat_o, '0);
      step();
      m_idle(0);
      step();

      // Simultaneous request after reset, handoff without IDLE gap, round robin
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      push(0, K_ACK, 1'b1, 128'h11110011_22220011_33330011_44440011);
      push(1, K_ACK, 1'b1, 128'h11110012_22220012_33330012_44440012);
      step();
      m_start(0, 16'h0011, 1'b0, '0, '1);
      m_start(1, 16'h0012, 1'b0, '0, '1);
      fork
         begin
            @(negedge clk);
            check("t2 idle before grant", DW'(grant_o), DW'(2'b00));
            @(negedge clk);
            check("t2 m0 first", DW'(grant_o), DW'(2'b01));
            wait_resp(0, "t2 m0");
            step();
            m_idle(0);
            @(negedge clk);
            check("t2 grant held to edge", DW'(grant_o), DW'(2'b01));
            @(negedge clk);
            check("t2 direct handoff", DW'(grant_o), DW'(2'b10));
         end
         begin
            wait_resp(1, "t2 m1");
            step();
            m_idle(1);
         end
      join
      step();
      step();
      m_cyc[0] = 1'b1;
      m_cyc[1] = 1'b1;
      @(negedge clk);
      check("t2 rr idle", DW'(grant_o), DW'(2'b00));
      @(negedge clk);
      check("t2 rr m0 wins", DW'(grant_o), DW'(2'b01));
      step();
      m_idle(0);
      m_idle(1);
      step();
      step();

      // m0 locks bus for 3 strobes while m1 waits to write
      push(0, K_ACK, 1'b1, 128'h11110020_22220020_33330020_44440020);
      push(0, K_ACK, 1'b1, 128'h11110021_22220021_33330021_44440021);
      push(0, K_ACK, 1'b1, 128'h11110022_22220022_33330022_44440022);
      push(1, K_ACK, 1'b0, '0);
      fork
         begin
            step();
            m_start(0, 16'h0020, 1'b0, '0, '1);
            for (int i = 0; i < 3; i++) begin
               wait_resp(0, "t3 m0");
               step();
               if (i < 2) m_adr[0] = 16'h0021 + 16'(i);
               else       m_idle(0);
            end
         end
         begin
            step();
            step();
            m_start(1, 16'h0020, 1'b1, 128'hDEADBEEF, 16'h000F);
            wait_resp(1, "t3 m1");
            step();
            m_idle(1);
         end
      join
      step();
      push(0, K_ACK, 1'b1, 128'h11110020_22220020_33330020_DEADBEEF);
      m_start(0, 16'h0020, 1'b0, '0, '1);
      wait_resp(0, "t3 readback");
      step();
      m_idle(0);
      step();

      // Watchdog with unresponsive slave
      slave_en = 1'b0;
      push(1, K_ERR, 1'b0, '0);
      step();
      m_start(1, 16'h0030, 1'b0, '0, '1);
      wait_grant(2'b10, "t4");
      ok = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         if (s_stb_o !== 1'b1 || m1_err_o !== 1'b0) ok = 1'b0;
      end
      check("t4 stb cycles 1-8 quiet", DW'(ok), 1);
      @(negedge clk);
      check("t4 err on 9th cycle", DW'(m1_err_o), 1);
      check("t4 stb/cyc forced low", DW'({s_stb_o, s_cyc_o}), '0);
      check("t4 grant at fire", DW'(grant_o), DW'(2'b10));
      step();
      m_stb[1] = 1'b0;
      @(negedge clk);
      check("t4 grant retained", DW'(grant_o), DW'(2'b10));
      check("t4 err one cycle", DW'(m1_err_o), 0);
      step();
      m_idle(1);
      @(negedge clk);
      @(negedge clk);
      check("t4 idle after release", DW'(grant_o), DW'(2'b00));

      // Asynchronous reset mid-transaction
      step();
      m_start(1, 16'h0040, 1'b0, '0, '1);
      wait_grant(2'b10, "t5");
      step();
      #1 rst = 1'b0;
      #1;
      check("t5 async grant", DW'(grant_o), '0);
      check("t5 async s_cyc/s_stb", DW'({s_cyc_o, s_stb_o}), '0);
      check("t5 async s_adr", DW'(s_adr_o), '0);
      m_idle(1);
      @(negedge clk) rst = 1'b1;
      step();
      m_cyc[0] = 1'b1;
      m_cyc[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5 m0 after reset", DW'(grant_o), DW'(2'b01));
      step();
      m_idle(0);
      m_idle(1);
      step();

      // Slave err and rty routed to owner only
      step();
      m_start(0, 16'h0050, 1'b0, '0, '1);
      wait_grant(2'b01, "t6");
      push(0, K_ERR, 1'b0, '0);
      step();
      s_err_i = 1'b1;
      @(negedge clk);
      check("t6 m0 err", DW'(m0_err_o), 1);
      check("t6 m1 quiet on err", DW'({m1_ack_o, m1_err_o, m1_rty_o}), '0);
      push(0, K_RTY, 1'b0, '0);
      step();
      s_err_i = 1'b0;
      s_rty_i = 1'b1;
      @(negedge clk);
      check("t6 m0 rty", DW'({m0_rty_o, m0_err_o}), DW'(2'b10));
      check("t6 m1 quiet on rty", DW'({m1_ack_o, m1_err_o, m1_rty_o}), '0);
      step();
      s_rty_i = 1'b0;
      m_idle(0);
      step();
      step();

      check("scoreboard drained", DW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
